// File: rtl/key_pkg.sv
// key_pkg: shared constants for the key debouncer.
// Channel FSM encoding, default timing and counter sizing.
package key_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;
  localparam logic [1:0] ST_REL   = 2'd3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 20000000;

  // Width that holds every terminal count (largest value minus one)
  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer_if: raw buttons in, command pulses out.
// master drives the buttons, slave is the debouncer side.
interface key_debouncer_if;

  logic btn_up;
  logic btn_left;
  logic btn_right;
  logic btn_confirm;
  logic up;
  logic left;
  logic right;
  logic confirm;

  modport master (
    output btn_up, btn_left, btn_right, btn_confirm,
    input  up, left, right, confirm
  );

  modport slave (
    input  btn_up, btn_left, btn_right, btn_confirm,
    output up, left, right, confirm
  );

endinterface

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one button, synchronizer + debounce FSM.
// Emits a registered one-cycle event per press and per repeat.
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic evt_o
);

  localparam int unsigned CW =
    cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [1:0]    sync_q, sync_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d;
  logic          evt_q, evt_d;
  logic          lvl;
  logic [CW-1:0] rep_last;

  assign lvl      = sync_q[1];
  assign rep_last = rep_q ? RP_LAST : RD_LAST;
  assign evt_o    = evt_q;

  // Next state: sync shift, debounce FSM, counter and repeat phase
  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    evt_d   = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        rep_d = 1'b0;
        if (lvl) begin
          state_d = ST_PRESS;
          cnt_d   = '0;
        end
      end
      (state_q == ST_PRESS): begin
        if (!lvl) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          rep_d   = 1'b0;
          evt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      (state_q == ST_HELD): begin
        if (!lvl) begin
          state_d = ST_REL;
          cnt_d   = '0;
        end else if (REPEAT_EN) begin
          if (cnt_q == rep_last) begin
            cnt_d = '0;
            rep_d = 1'b1;
            evt_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      (state_q == ST_REL): begin
        if (lvl) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Channel state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      evt_q   <= evt_d;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: four debounced buttons to command pulses.
// Directions arbitrate up > left > right; confirm is deferred.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_i,
  input  logic btn_left_i,
  input  logic btn_right_i,
  input  logic btn_confirm_i,
  output logic up_o,
  output logic left_o,
  output logic right_o,
  output logic confirm_o
);

  logic ev_up, ev_left, ev_right, ev_conf;
  logic up_q, up_d;
  logic left_q, left_d;
  logic right_q, right_d;
  logic conf_q, conf_d;
  logic pend_q, pend_d;
  logic dir;
  logic want;

  key_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b0)
  ) u_ch_up (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_up_i),
    .evt_o (ev_up)
  );

  key_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b1)
  ) u_ch_left (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_left_i),
    .evt_o (ev_left)
  );

  key_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b1)
  ) u_ch_right (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_right_i),
    .evt_o (ev_right)
  );

  key_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b0)
  ) u_ch_conf (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_confirm_i),
    .evt_o (ev_conf)
  );

  assign up_o      = up_q;
  assign left_o    = left_q;
  assign right_o   = right_q;
  assign confirm_o = conf_q;

  // Priority pick of one direction; confirm waits out a direction
  always_comb begin
    dir     = ev_up | ev_left | ev_right;
    want    = ev_conf | pend_q;
    up_d    = ev_up;
    left_d  = ev_left & ~ev_up;
    right_d = ev_right & ~ev_up & ~ev_left;
    conf_d  = want & ~dir;
    pend_d  = want & dir;
  end

  // Output pulse and pending registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_q    <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      conf_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      up_q    <= up_d;
      left_q  <= left_d;
      right_q <= right_d;
      conf_q  <= conf_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed vectors with hand-computed traces.
// Bit order everywhere is {up, left, right, confirm}.
module tb_key_debouncer;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;
  localparam int N = 64;

  logic clk = 1'b0;
  logic rst;

  key_debouncer_if bus ();

  key_debouncer #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_up_i      (bus.btn_up),
    .btn_left_i    (bus.btn_left),
    .btn_right_i   (bus.btn_right),
    .btn_confirm_i (bus.btn_confirm),
    .up_o          (bus.up),
    .left_o        (bus.left),
    .right_o       (bus.right),
    .confirm_o     (bus.confirm)
  );

  always #5 clk = ~clk;

  logic [3:0] outs;
  assign outs = {bus.up, bus.left, bus.right, bus.confirm};

  int n_run  = 0;
  int n_fail = 0;

  logic [3:0] stim [0:N-1];
  logic [3:0] tr   [0:N-1];
  logic [3:0] ex   [0:N-1];

  task automatic check(
    input string      tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {bus.btn_up, bus.btn_left, bus.btn_right, bus.btn_confirm} = v;
  endtask

  task automatic clear();
    for (int i = 0; i < N; i++) begin
      stim[i] = '0;
      tr[i]   = '0;
      ex[i]   = '0;
    end
  endtask

  task automatic fill(input int a, input int b, input logic [3:0] v);
    for (int i = a; i <= b; i++) stim[i] = v;
  endtask

  // stim[i] is sampled by edge i; tr[i] is the output after edge i
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive(stim[i]);
      @(posedge clk);
      #1;
      tr[i] = outs;
    end
  endtask

  task automatic cmp(input string name, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", name, i), tr[i], ex[i]);
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs, 4'b0000);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive('0);
    do_reset();

    // left held: single pulse after edge 7, then async reset clears it
    clear();
    fill(0, 15, 4'b0100);
    ex[7] = 4'b0100;
    run(8);
    cmp("left_press", 8);
    rst = 1'b0;
    #1;
    check("async_rst", outs, 4'b0000);
    do_reset();

    // up glitches of 3 cycles never qualify
    clear();
    fill(0, 2, 4'b1000);
    fill(4, 6, 4'b1000);
    run(20);
    cmp("up_glitch", 20);
    do_reset();

    // right held 40 cycles: press, +10, then every 5, none on release
    clear();
    fill(0, 39, 4'b0010);
    ex[7]  = 4'b0010;
    ex[17] = 4'b0010;
    ex[22] = 4'b0010;
    ex[27] = 4'b0010;
    ex[32] = 4'b0010;
    ex[37] = 4'b0010;
    ex[42] = 4'b0010;
    run(60);
    cmp("right_rep", 60);
    do_reset();

    // up and left together: up wins, left dropped
    clear();
    fill(0, 9, 4'b1100);
    ex[7] = 4'b1000;
    run(20);
    cmp("up_left", 20);
    do_reset();

    // confirm with right: right first, confirm one cycle later
    clear();
    fill(0, 9, 4'b0011);
    ex[7] = 4'b0010;
    ex[8] = 4'b0001;
    run(20);
    cmp("right_conf", 20);
    do_reset();

    // up held long: no auto-repeat
    clear();
    fill(0, 39, 4'b1000);
    ex[7] = 4'b1000;
    run(45);
    cmp("up_norep", 45);
    do_reset();

    // reset mid press-check of confirm, released with button held
    clear();
    fill(0, 3, 4'b0001);
    run(4);
    cmp("conf_pre", 4);
    rst = 1'b0;
    drive(4'b0001);
    repeat (3) @(posedge clk);
    #1;
    check("conf_in_rst", outs, 4'b0000);
    rst = 1'b1;
    clear();
    fill(0, 19, 4'b0001);
    ex[7] = 4'b0001;
    run(20);
    cmp("conf_after_rst", 20);
    do_reset();

    // reset mid repeat wait of left discards the pending repeat
    clear();
    fill(0, 13, 4'b0100);
    ex[7] = 4'b0100;
    run(14);
    cmp("left_pre_abort", 14);
    rst = 1'b0;
    drive('0);
    repeat (3) @(posedge clk);
    #1;
    check("left_in_rst", outs, 4'b0000);
    rst = 1'b1;
    clear();
    run(20);
    cmp("left_abort", 20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
